bsg_circular_slot_alloc: RTL and testbench

Allocates and frees contiguous runs of slots in a circular buffer of `slots_p` entries. A producer claims 0..`max_add_p` slots per handshake, and a consumer releases the oldest slots in order. The block owns both the write (allocate) pointer and the read (free) pointer, tracks occupancy, and flags illegal requests. It sits in front of ring-buffer storage (reorder buffers, packet buffers) and is the sequencer for the circular-pointer datapath.

---
 rtl/bsg_circular_slot_alloc_pkg.sv | 26 ++
 rtl/bsg_circular_ptr_ar.sv | 42 ++++
 rtl/bsg_circular_slot_alloc.sv | 119 +++++++++++
 tb/tb_bsg_circular_slot_alloc.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_circular_slot_alloc_pkg.sv
// Shared types and width helpers for the circular slot allocator.
package bsg_circular_slot_alloc_pkg;

    // Wide enough to hold any request count or slot total without overflow.
    localparam int unsigned ReqNumW = 32;

    typedef struct packed {
        logic [ReqNumW-1:0] num;
    } alloc_req_s;

    // Count width: holds 0..max_add inclusive.
    function automatic int unsigned calc_cw(input int unsigned max_add);
        return $clog2(max_add + 1);
    endfunction

    // Pointer width: indexes 0..slots-1.
    function automatic int unsigned calc_ptr_w(input int unsigned slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    // Occupancy width: holds 0..slots inclusive.
    function automatic int unsigned calc_used_w(input int unsigned slots);
        return $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/bsg_circular_ptr_ar.sv
// Modulo-slots_p pointer with enable and add amount; async active-high reset.
module bsg_circular_ptr_ar
    import bsg_circular_slot_alloc_pkg::*;
#(
    parameter int unsigned slots_p   = 32,
    parameter int unsigned max_add_p = 5,
    localparam int unsigned Cw = calc_cw(max_add_p),
    localparam int unsigned Pw = calc_ptr_w(slots_p)
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          i_en,
    input  logic [Cw-1:0] i_add,
    output logic [Pw-1:0] o_ptr
);

    // One extra bit so ptr + add never overflows before the wrap compare.
    localparam int unsigned Sw = Pw + 1;
    localparam logic [Sw-1:0] SlotsW = Sw'(slots_p);

    logic [Pw-1:0] r_ptr;
    logic [Sw-1:0] w_sum;
    logic [Sw-1:0] w_wrap;

    // Advance and fold back into 0..slots_p-1 (works for non-power-of-two sizes).
    always_comb begin
        w_sum  = {1'b0, r_ptr} + Sw'(i_add);
        w_wrap = (w_sum >= SlotsW) ? (w_sum - SlotsW) : w_sum;
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= w_wrap[Pw-1:0];
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/bsg_circular_slot_alloc.sv
// Allocates/frees contiguous runs of slots in a circular buffer; tracks
// occupancy and flags illegal requests with a sticky error.
module bsg_circular_slot_alloc
    import bsg_circular_slot_alloc_pkg::*;
#(
    parameter int unsigned slots_p   = 32,
    parameter int unsigned max_add_p = 5,
    localparam int unsigned Cw = calc_cw(max_add_p),
    localparam int unsigned Pw = calc_ptr_w(slots_p),
    localparam int unsigned Uw = calc_used_w(slots_p)
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          alloc_v_i,
    input  logic [Cw-1:0] alloc_num_i,
    output logic          alloc_ready_o,
    output logic [Pw-1:0] alloc_base_o,
    input  logic          free_v_i,
    input  logic [Cw-1:0] free_num_i,
    output logic [Pw-1:0] rptr_o,
    output logic [Uw-1:0] used_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          error_o
);

    localparam logic [ReqNumW-1:0] SlotsN = ReqNumW'(slots_p);
    localparam logic [ReqNumW-1:0] MaxN   = ReqNumW'(max_add_p);

    logic [Uw-1:0]      r_used;
    logic               r_full;
    logic               r_empty;
    logic               r_error;

    alloc_req_s         w_alloc_req;
    alloc_req_s         w_free_req;
    logic [ReqNumW-1:0] w_used_ext;
    logic [ReqNumW-1:0] w_space;
    logic [ReqNumW-1:0] w_used_next;
    logic               w_alloc_ready;
    logic               w_alloc_fire;
    logic               w_alloc_bad;
    logic               w_free_ok;
    logic               w_free_bad;
    logic [Pw-1:0]      w_wptr;
    logic [Pw-1:0]      w_rptr;

    // Request decode, readiness and legality; readiness ignores same-cycle frees.
    always_comb begin
        w_alloc_req.num = ReqNumW'(alloc_num_i);
        w_free_req.num  = ReqNumW'(free_num_i);
        w_used_ext      = ReqNumW'(r_used);
        w_space         = SlotsN - w_used_ext;

        w_alloc_ready = (w_alloc_req.num <= MaxN) && (w_space >= w_alloc_req.num);
        w_alloc_fire  = alloc_v_i && w_alloc_ready;
        w_alloc_bad   = alloc_v_i && (w_alloc_req.num > MaxN);

        w_free_bad = free_v_i && ((w_free_req.num > MaxN) || (w_free_req.num > w_used_ext));
        w_free_ok  = free_v_i && !w_free_bad;
    end

    // Next occupancy: both legal requests apply in the same cycle.
    always_comb begin
        w_used_next = w_used_ext;
        if (w_alloc_fire) begin
            w_used_next = w_used_next + w_alloc_req.num;
        end
        if (w_free_ok) begin
            w_used_next = w_used_next - w_free_req.num;
        end
    end

    // Occupancy, full/empty flags and sticky error.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_used  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_error <= 1'b0;
        end else begin
            r_used  <= w_used_next[Uw-1:0];
            r_full  <= (w_used_next == SlotsN);
            r_empty <= (w_used_next == '0);
            r_error <= r_error | w_alloc_bad | w_free_bad;
        end
    end

    bsg_circular_ptr_ar #(
        .slots_p   (slots_p),
        .max_add_p (max_add_p)
    ) u_wptr (
        .clk     (clk),
        .reset_i (reset_i),
        .i_en    (w_alloc_fire),
        .i_add   (alloc_num_i),
        .o_ptr   (w_wptr)
    );

    bsg_circular_ptr_ar #(
        .slots_p   (slots_p),
        .max_add_p (max_add_p)
    ) u_rptr (
        .clk     (clk),
        .reset_i (reset_i),
        .i_en    (w_free_ok),
        .i_add   (free_num_i),
        .o_ptr   (w_rptr)
    );

    assign alloc_ready_o = w_alloc_ready;
    assign alloc_base_o  = w_wptr;
    assign rptr_o        = w_rptr;
    assign used_o        = r_used;
    assign full_o        = r_full;
    assign empty_o       = r_empty;
    assign error_o       = r_error;

endmodule

// File: tb/tb_bsg_circular_slot_alloc.sv
// Self-checking bench: vector table, hand-written corner sequences, and
// randomized traffic against a queue-of-slots reference model.
module tb_bsg_circular_slot_alloc;

    localparam int S = 32;
    localparam int M = 5;

    logic       clk;
    logic       reset_i;

    logic       av, fv, ready, full, empty, err;
    logic [2:0] an, fn;
    logic [4:0] base, rptr;
    logic [5:0] used;

    logic       av_b, fv_b, ready_b, full_b, empty_b, err_b;
    logic [2:0] an_b, fn_b;
    logic [3:0] base_b, rptr_b, used_b;

    int n_checks;
    int n_errors;

    bsg_circular_slot_alloc #(
        .slots_p   (32),
        .max_add_p (5)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .alloc_v_i     (av),
        .alloc_num_i   (an),
        .alloc_ready_o (ready),
        .alloc_base_o  (base),
        .free_v_i      (fv),
        .free_num_i    (fn),
        .rptr_o        (rptr),
        .used_o        (used),
        .full_o        (full),
        .empty_o       (empty),
        .error_o       (err)
    );

    bsg_circular_slot_alloc #(
        .slots_p   (12),
        .max_add_p (5)
    ) dut12 (
        .clk           (clk),
        .reset_i       (reset_i),
        .alloc_v_i     (av_b),
        .alloc_num_i   (an_b),
        .alloc_ready_o (ready_b),
        .alloc_base_o  (base_b),
        .free_v_i      (fv_b),
        .free_num_i    (fn_b),
        .rptr_o        (rptr_b),
        .used_o        (used_b),
        .full_o        (full_b),
        .empty_o       (empty_b),
        .error_o       (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the allocated slots as an oldest-first queue of indices.
    int q[$];
    int m_wptr;
    bit m_err;

    function automatic void m_reset();
        q.delete();
        m_wptr = 0;
        m_err  = 0;
    endfunction

    function automatic bit m_ready(input int n);
        return (n <= M) && ((S - q.size()) >= n);
    endfunction

    function automatic int m_rptr();
        return (q.size() == 0) ? m_wptr : q[0];
    endfunction

    function automatic void m_step(input bit a, input int n, input bit f, input int k);
        bit fire;
        fire = a && m_ready(n);
        if (a && n > M) m_err = 1;
        if (f) begin
            if (k > M || k > q.size()) m_err = 1;
            else repeat (k) void'(q.pop_front());
        end
        if (fire) begin
            for (int i = 0; i < n; i++) q.push_back((m_wptr + i) % S);
            m_wptr = (m_wptr + n) % S;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit a, input int n, input bit f, input int k);
        av = a;
        an = 3'(n);
        fv = f;
        fn = 3'(k);
    endtask

    task automatic set_b(input bit a, input int n, input bit f, input int k);
        av_b = a;
        an_b = 3'(n);
        fv_b = f;
        fn_b = 3'(k);
    endtask

    task automatic step(input bit a, input int n, input bit f, input int k);
        set_in(a, n, f, k);
        tick();
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        reset_i = 1'b1;
        #2;
        tick();
        reset_i = 1'b0;
        m_reset();
    endtask

    task automatic rcycle(input bit a, input int n, input bit f, input int k);
        set_in(a, n, f, k);
        #1;
        check("rnd_ready", int'(ready), int'(m_ready(n)));
        check("rnd_base", int'(base), m_wptr);
        m_step(a, n, f, k);
        tick();
        check("rnd_used", int'(used), q.size());
        check("rnd_rptr", int'(rptr), m_rptr());
        check("rnd_full", int'(full), int'(q.size() == S));
        check("rnd_empty", int'(empty), int'(q.size() == 0));
        check("rnd_error", int'(err), int'(m_err));
    endtask

    typedef struct {
        bit av;
        int an;
        bit fv;
        int fn;
        bit e_ready;
        int e_base;
        int e_used;
        int e_rptr;
        bit e_full;
        bit e_err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_i  = 1'b1;
        set_in(0, 0, 0, 0);
        set_b(0, 0, 0, 0);

        // Fill from reset, stall on lack of space, then drain and mixed requests.
        tbl[0]  = '{1, 5, 0, 0, 1,  0,  5,  0, 0, 0};
        tbl[1]  = '{1, 5, 0, 0, 1,  5, 10,  0, 0, 0};
        tbl[2]  = '{1, 5, 0, 0, 1, 10, 15,  0, 0, 0};
        tbl[3]  = '{1, 5, 0, 0, 1, 15, 20,  0, 0, 0};
        tbl[4]  = '{1, 5, 0, 0, 1, 20, 25,  0, 0, 0};
        tbl[5]  = '{1, 5, 0, 0, 1, 25, 30,  0, 0, 0};
        tbl[6]  = '{1, 3, 0, 0, 0, 30, 30,  0, 0, 0};
        tbl[7]  = '{1, 3, 1, 1, 0, 30, 29,  1, 0, 0};
        tbl[8]  = '{1, 3, 0, 0, 1, 30, 32,  1, 1, 0};
        tbl[9]  = '{0, 0, 1, 4, 1,  1, 28,  5, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 1,  1, 28,  5, 0, 0};
        tbl[11] = '{1, 6, 1, 5, 0,  1, 23, 10, 0, 1};

        do_reset();
        check("rst_used", int'(used), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_rptr", int'(rptr), 0);
        check("rst_base", int'(base), 0);
        check("rst_error", int'(err), 0);
        check("rst_ready_zero", int'(ready), 1);

        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].av, tbl[i].an, tbl[i].fv, tbl[i].fn);
            #1;
            check($sformatf("tbl%0d_ready", i), int'(ready), int'(tbl[i].e_ready));
            check($sformatf("tbl%0d_base", i), int'(base), tbl[i].e_base);
            tick();
            check($sformatf("tbl%0d_used", i), int'(used), tbl[i].e_used);
            check($sformatf("tbl%0d_rptr", i), int'(rptr), tbl[i].e_rptr);
            check($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].e_full));
            check($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].e_used == 0));
            check($sformatf("tbl%0d_error", i), int'(err), int'(tbl[i].e_err));
        end

        // Fill to 32, free 5, allocate 5 across the wrap.
        do_reset();
        repeat (6) step(1, 5, 0, 0);
        step(1, 2, 0, 0);
        check("fill_full", int'(full), 1);
        check("fill_used", int'(used), 32);
        step(0, 0, 1, 5);
        check("fill_rptr", int'(rptr), 5);
        set_in(1, 5, 0, 0);
        #1;
        check("wrap_ready", int'(ready), 1);
        check("wrap_base", int'(base), 0);
        tick();
        check("wrap_used", int'(used), 32);
        check("wrap_full", int'(full), 1);
        check("wrap_rptr", int'(rptr), 5);
        check("wrap_wptr_eq_rptr", int'(base), 5);

        // Simultaneous allocate and free.
        do_reset();
        step(1, 4, 0, 0);
        step(1, 3, 1, 2);
        check("sim_used5", int'(used), 5);
        do_reset();
        repeat (6) step(1, 5, 0, 0);
        step(1, 1, 0, 0);
        check("sim_used31", int'(used), 31);
        set_in(1, 2, 1, 2);
        #1;
        check("sim31_ready", int'(ready), 0);
        tick();
        check("sim31_used", int'(used), 29);
        check("sim31_rptr", int'(rptr), 2);

        // Illegal requests set a sticky error without disturbing state.
        do_reset();
        step(1, 2, 0, 0);
        step(0, 0, 1, 3);
        check("ovfree_error", int'(err), 1);
        check("ovfree_used", int'(used), 2);
        check("ovfree_rptr", int'(rptr), 0);
        step(0, 0, 1, 2);
        check("legfree_used", int'(used), 0);
        check("legfree_rptr", int'(rptr), 2);
        check("legfree_error", int'(err), 1);
        do_reset();
        check("err_cleared", int'(err), 0);
        set_in(1, 7, 0, 0);
        #1;
        check("big_alloc_ready", int'(ready), 0);
        tick();
        check("big_alloc_error", int'(err), 1);
        check("big_alloc_used", int'(used), 0);
        check("big_alloc_base", int'(base), 0);

        // Non-power-of-two ring: wptr 0, 5, 10, 3.
        do_reset();
        set_b(1, 5, 0, 0);
        #1;
        check("s12_base0", int'(base_b), 0);
        tick();
        set_b(0, 0, 1, 5);
        tick();
        set_b(1, 5, 0, 0);
        #1;
        check("s12_base5", int'(base_b), 5);
        tick();
        set_b(0, 0, 1, 5);
        tick();
        set_b(1, 5, 0, 0);
        #1;
        check("s12_base10", int'(base_b), 10);
        tick();
        set_b(0, 0, 1, 5);
        tick();
        set_b(0, 0, 0, 0);
        #1;
        check("s12_base3", int'(base_b), 3);
        check("s12_rptr3", int'(rptr_b), 3);
        check("s12_used0", int'(used_b), 0);

        // Asynchronous reset between edges.
        do_reset();
        repeat (3) step(1, 5, 0, 0);
        step(1, 7, 0, 0);
        set_in(1, 5, 1, 2);
        tick();
        check("pre_arst_used", int'(used), 18);
        check("pre_arst_error", int'(err), 1);
        #3;
        reset_i = 1'b1;
        #1;
        check("arst_used", int'(used), 0);
        check("arst_empty", int'(empty), 1);
        check("arst_full", int'(full), 0);
        check("arst_rptr", int'(rptr), 0);
        check("arst_base", int'(base), 0);
        check("arst_error", int'(err), 0);
        set_in(0, 0, 0, 0);
        tick();
        reset_i = 1'b0;
        m_reset();

        // Randomized traffic against the queue model.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                bit a;
                bit f;
                int n;
                int k;
                int lim;
                a = ($urandom_range(0, 99) < 60);
                n = ($urandom_range(0, 49) == 0) ? int'($urandom_range(6, 7))
                                                 : int'($urandom_range(0, 5));
                f = ($urandom_range(0, 99) < 45);
                lim = (q.size() < M) ? q.size() : M;
                k = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 7))
                                                 : int'($urandom_range(0, lim));
                rcycle(a, n, f, k);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
